// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with H/V counters, syncs, blanking, frame and periodic ticks
// Counters, decodes and ticks are all registered from the next-state values, so they are always mutually aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int FRAMES_PER_TICK = 60
) (
  input  logic        CLK,
  input  logic        iRST_N,
  input  logic        iPIX_EN,
  output logic [15:0] oH_CNT,
  output logic [15:0] oV_CNT,
  output logic        oHS,
  output logic        oVS,
  output logic        oBLANK_N,
  output logic        oFRAME_TICK,
  output logic        oSEC_TICK
);

  localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_VIS  = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  // A single-frame period still needs a one-bit counter that simply stays at zero.
  localparam int FCW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
  localparam logic [FCW-1:0] F_LAST = FCW'(FRAMES_PER_TICK - 1);

  logic [15:0]    h_next;
  logic [15:0]    v_next;
  logic           frame_wrap;
  logic [FCW-1:0] frame_cnt;

  always_comb begin
    h_next     = oH_CNT;
    v_next     = oV_CNT;
    frame_wrap = 1'b0;
    if (iPIX_EN) begin
      if (oH_CNT == H_LAST) begin
        h_next = '0;
        if (oV_CNT == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = oV_CNT + 16'd1;
        end
      end else begin
        h_next = oH_CNT + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oH_CNT      <= '0;
      oV_CNT      <= '0;
      oHS         <= 1'b1;
      oVS         <= 1'b1;
      oBLANK_N    <= 1'b1;
      oFRAME_TICK <= 1'b0;
      oSEC_TICK   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      oH_CNT      <= h_next;
      oV_CNT      <= v_next;
      oHS         <= !((h_next >= HS_BEG) && (h_next <= HS_END));
      oVS         <= !((v_next >= VS_BEG) && (v_next <= VS_END));
      oBLANK_N    <= (h_next < H_VIS) && (v_next < V_VIS);
      oFRAME_TICK <= frame_wrap;
      oSEC_TICK   <= frame_wrap && (frame_cnt == F_LAST);
      if (frame_wrap) begin
        frame_cnt <= (frame_cnt == F_LAST) ? '0 : frame_cnt + FCW'(1);
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator that produces the horizontal and vertical pixel counters (`H_CNT`/`V_CNT`), sync, and blanking strobes consumed by pixel-processing and sampling blocks downstream. It is the producing end of the `H_CNT`/`V_CNT` raster interface: consumers compare against these counts (e.g. screen centre 320/240) to pick pixels. It also emits a one-cycle frame tick and a slower periodic tick (default once per second at 60 fps), so consumers need no frame counters of their own.

## Interface

- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `FRAMES_PER_TICK`, 60, frames per `oSEC_TICK` pulse (≥1)
- `CLK` in 1 system clock
- `iRST_N` in 1 reset; asynchronous, active-low
- `iPIX_EN` in 1 pixel-advance enable; the raster steps one pixel per cycle where `iPIX_EN=1`
- `oH_CNT` out 16 horizontal position, 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800)
- `oV_CNT` out 16 vertical position, 0..V_TOTAL-1, where V_TOTAL = sum of the V parameters (525)
- `oHS` out 1 horizontal sync, active-low
- `oVS` out 1 vertical sync, active-low
- `oBLANK_N` out 1 1 = active video at the current (H,V)
- `oFRAME_TICK` out 1 one-cycle pulse when the raster wraps to (0,0)
- `oSEC_TICK` out 1 one-cycle pulse on every FRAMES_PER_TICK-th frame wrap

## Operation

- **Coordinates:** (0,0) is the first active pixel. The horizontal sequence is active 0..H_ACTIVE-1, then front porch, then sync, then back porch; vertical follows the same order in lines.
- **No advance:** when `iPIX_EN=0`, all counters and outputs hold, and both ticks are 0.
- **Horizontal advance:** when `iPIX_EN=1`, `oH_CNT` increments. At H_TOTAL-1 it wraps to 0.
- **Vertical advance:** `oV_CNT` increments only on an H wrap. It wraps to 0 when H and V wrap together from (H_TOTAL-1, V_TOTAL-1).
- **Decode:**
  - `oHS=0` iff H_ACTIVE+H_FP ≤ H ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751 at defaults).
  - `oVS=0` iff V_ACTIVE+V_FP ≤ V ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491 at defaults).
  - `oBLANK_N=1` iff H<H_ACTIVE and V<V_ACTIVE.
- **Frame counter:** internal, range 0..FRAMES_PER_TICK-1, incremented on each frame wrap.
  - When the frame counter wraps to 0, `oSEC_TICK` pulses in the same cycle as `oFRAME_TICK`.
  - With FRAMES_PER_TICK=1, `oSEC_TICK` equals `oFRAME_TICK`.
- **Reset values:** `oH_CNT=0`, `oV_CNT=0`, `oHS=1`, `oVS=1`, `oBLANK_N=1`, `oFRAME_TICK=0`, `oSEC_TICK=0`, frame counter 0.
- **Reset mid-frame:** the raster restarts at (0,0) immediately with the values above. Reset itself produces no frame tick.
- **Tick counting after reset:** the first `oFRAME_TICK` comes after one full frame of enabled cycles (H_TOTAL·V_TOTAL). The first `oSEC_TICK` comes after FRAMES_PER_TICK full frames.

## Timing

- All outputs are registers with no combinational path from inputs.
- `oHS`, `oVS` and `oBLANK_N` are decoded from the next counter values and registered with them. They therefore describe exactly the `oH_CNT`/`oV_CNT` presented in the same cycle, with zero skew.
- **Latency:** `iPIX_EN` sampled high at edge k updates outputs after edge k. A consumer comparing counts sees each (H,V) value held for exactly the cycles between two enabled edges.
- **Ticks:** `oFRAME_TICK`/`oSEC_TICK` are high for exactly one CLK cycle: the cycle in which outputs first show (0,0) after a wrap. They are 0 on the next cycle, even if `iPIX_EN=0` holds the raster at (0,0).
- **Deassertion:** `iRST_N` deassertion is synchronised by the environment. The first advance occurs on the first enabled edge after release.

## Test plan

- **Reset and hold:** assert `iRST_N=0` mid-line at H=400/V=100 → outputs immediately read H=0, V=0, HS=1, VS=1, BLANK_N=1, ticks 0. Then `iPIX_EN=0` for 10 cycles → all outputs hold.
- **Horizontal line:** `iPIX_EN=1` continuously for one line →
  - `oBLANK_N` falls when H goes 639→640.
  - `oHS` is low for exactly 96 cycles (H 656..751).
  - H goes 799→0 and V goes 0→1 in the same cycle.
- **Full frame:** `iPIX_EN=1` for 420000 cycles (800·525) →
  - `oVS` is low for exactly 1600 cycles, over lines 490..491.
  - `oBLANK_N` is high for exactly 307200 cycles.
  - `oFRAME_TICK` pulses once, on return to (0,0).
- **Half-rate enable:** `iPIX_EN` toggles every cycle →
  - each (H,V) value is held for 2 cycles;
  - the frame wraps after 840000 cycles;
  - `oFRAME_TICK` is still 1 cycle wide.
- **Second tick:** FRAMES_PER_TICK=3, 12 frames → `oSEC_TICK` pulses at frame wraps 3, 6, 9 and 12, each coincident with `oFRAME_TICK`; no other pulses.
- **Consumer-centre check:** H=320, V=240 is reached exactly once per frame, with `oBLANK_N=1` at that point.
